// File: rtl/ex_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: default widths, op encodings, FSM states.
package ex_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_REM   = 3'd6;
  localparam logic [2:0] OP_REMU  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ex_muldiv_core.sv
// Radix-2 shift-add multiply / restoring divide datapath, one iteration per step.
// Next-state values are exposed so the final step's result can be captured on the same edge.
module ex_muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] opnd_in,
  input  logic [XLEN-1:0] lo_in,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] lo_next
);
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [XLEN:0]   sum;
  logic [XLEN+1:0] diff;

  // mul: {acc,lo} shifts right, lo holds the multiplier; div: {acc,lo} shifts left, lo collects quotient bits
  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    diff = {1'b0, acc, lo[XLEN-1]} - {2'b00, opnd};
    if (is_div) begin
      acc_next = diff[XLEN+1] ? {acc[XLEN-2:0], lo[XLEN-1]} : diff[XLEN-1:0];
      lo_next  = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      acc_next = sum[XLEN:1];
      lo_next  = {sum[0], lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= '0;
      lo   <= lo_in;
      opnd <= opnd_in;
    end else if (step) begin
      acc  <= acc_next;
      lo   <= lo_next;
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative mul/div: XLEN+1 cycles from accept to done_o, stall_o holds upstream meanwhile.
// MULDIV_FAST_ZERO_EN: zero operands (b==0, or a==0 for multiplies) complete one cycle after accept.
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] RS1data_i,
  input  logic [XLEN-1:0] RS2data_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic            neg_q, neg_r;
  logic            accept, busy, last, fast_hit;
  logic            sdiv_in, a_neg, b_neg, b_zero;
  logic [XLEN-1:0] abs_a, abs_b, lo_in, opnd_in;
  logic [XLEN-1:0] acc_next, lo_next, quot, remd, final_res;

  assign busy    = (state == ST_BUSY);
  assign accept  = (state == ST_IDLE) & valid_i & ~flush_i;
  assign last    = (cnt == CNT_W'(XLEN-1));
  assign stall_o = accept | busy;
  assign done_o  = (state == ST_DONE);

  assign sdiv_in = op_i[2] & ~op_i[0];
  assign a_neg   = RS1data_i[XLEN-1];
  assign b_neg   = RS2data_i[XLEN-1];
  assign b_zero  = (RS2data_i == '0);
  assign abs_a   = (sdiv_in & a_neg) ? -RS1data_i : RS1data_i;
  assign abs_b   = (sdiv_in & b_neg) ? -RS2data_i : RS2data_i;
  assign lo_in   = op_i[2] ? abs_a : RS2data_i;
  assign opnd_in = op_i[2] ? abs_b : RS1data_i;

`ifdef MULDIV_FAST_ZERO_EN
  logic            fast_zero;
  logic [XLEN-1:0] fast_res;
  assign fast_zero = b_zero | (~|RS1data_i & ~op_i[2]);
  assign fast_res  = ~op_i[2] ? '0 : (op_i[1] ? RS1data_i : '1);
  assign fast_hit  = accept & fast_zero;
`else
  assign fast_hit  = 1'b0;
`endif

  ex_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (accept),
    .step     (busy),
    .is_div   (op_q[2]),
    .opnd_in  (opnd_in),
    .lo_in    (lo_in),
    .acc_next (acc_next),
    .lo_next  (lo_next)
  );

  // Sign fix on magnitudes; divide-by-zero never sets neg_q so the all-ones quotient survives
  assign quot = neg_q ? -lo_next : lo_next;
  assign remd = neg_r ? -acc_next : acc_next;

  always_comb begin
    case (op_q)
      OP_MULHU:        final_res = acc_next;
      OP_DIV, OP_DIVU: final_res = quot;
      OP_REM, OP_REMU: final_res = remd;
      default:         final_res = lo_next;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = fast_hit ? ST_DONE : ST_BUSY;
      ST_BUSY: if (flush_i) state_nxt = ST_IDLE;
               else if (last) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= '0;
        op_q  <= op_i;
        neg_q <= sdiv_in & (a_neg ^ b_neg) & ~b_zero;
        neg_r <= sdiv_in & a_neg;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      if (busy & ~flush_i & last) begin
        result_o <= final_res;
      end
`ifdef MULDIV_FAST_ZERO_EN
      else if (fast_hit) begin
        result_o <= fast_res;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed spec cases, flush, async reset, random ops vs arithmetic model.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   (valid),
    .flush_i   (flush),
    .op_i      (op),
    .RS1data_i (rs1),
    .RS2data_i (rs2),
    .stall_o   (stall),
    .done_o    (done),
    .result_o  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    p   = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd1: return p[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      3'd7: return (b == 0) ? a : a % b;
      default: return p[31:0];
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    if (b == 0 || (a == 0 && !o[2])) return 1;
`endif
    return 33;
  endfunction

  // Issue one op in the next cycle and follow it to done_o, bounded by a cycle budget
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls, output logic st_done);
    @(negedge clk);
    valid = 1'b1; op = o; rs1 = a; rs2 = b;
    #1;
    lat = 0; stalls = 0; res = 'x; st_done = 1'b1;
    while (!done && lat < 200) begin
      if (stall) stalls++;
      @(negedge clk); #1;
      lat++;
    end
    if (done) begin
      res = result;
      st_done = stall;
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset: stall=%b done=%b result=%h, want 0/0/0", stall, done, result);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [10] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd6, 3'd2, 3'd0};
    logic [31:0] t_a  [10] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5,
                               32'hFFFFFFFB, 32'h80000000, 32'h80000000, 32'd6, 32'd0};
    logic [31:0] t_b  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd0,
                               32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd5};
    logic [31:0] t_r  [10] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFB, 32'h80000000, 32'd0, 32'd42, 32'd0};
    logic [31:0] res;
    int lat, stalls, el;
    logic st_done;
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, lat, stalls, st_done);
      el = exp_lat(t_op[i], t_a[i], t_b[i]);
      checks++;
      if (res !== t_r[i]) begin
        errors++;
        $display("FAIL directed[%0d] result: got %h want %h", i, res, t_r[i]);
      end
      checks++;
      if (lat != el) begin
        errors++;
        $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, el);
      end
      checks++;
      if (stalls != el) begin
        errors++;
        $display("FAIL directed[%0d] stall cycles: got %0d want %0d", i, stalls, el);
      end
      checks++;
      if (st_done !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] stall in done cycle: got %b want 0", i, st_done);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int lat, stalls, pulses;
    logic st_done;
    prev = result;
    @(negedge clk);
    valid = 1'b1; op = 3'd0; rs1 = 32'h1234_5678; rs2 = 32'h9;
    repeat (11) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush busy stall: got %b want 1", stall);
    end
    flush = 1'b1; valid = 1'b0;
    @(negedge clk); #1;
    flush = 1'b0;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush stall drop: got %b want 0", stall);
    end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      @(negedge clk); #1;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush done pulses: got %0d want 0", pulses);
    end
    checks++;
    if (result !== prev) begin
      errors++;
      $display("FAIL flush result held: got %h want %h", result, prev);
    end
    run_op(3'd0, 32'd2, 32'd3, res, lat, stalls, st_done);
    checks++;
    if (res !== 32'd6 || lat != 33) begin
      errors++;
      $display("FAIL post-flush mul: got %h lat %0d want 00000006 lat 33", res, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat, stalls;
    logic st_done;
    @(negedge clk);
    valid = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    repeat (5) @(negedge clk);
    #1;
    valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL async reset: stall=%b done=%b result=%h want 0/0/0", stall, done, result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, res, lat, stalls, st_done);
    checks++;
    if (res !== 32'd14 || lat != 33) begin
      errors++;
      $display("FAIL after reset divu: got %h lat %0d want 0000000e lat 33", res, lat);
    end
    run_op(3'd7, 32'd100, 32'd7, res, lat, stalls, st_done);
    checks++;
    if (res !== 32'd2 || lat != 33) begin
      errors++;
      $display("FAIL after reset remu: got %h lat %0d want 00000002 lat 33", res, lat);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, res, exp;
    int lat, stalls, el;
    logic st_done;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      exp = ref_model(o, a, b);
      el  = exp_lat(o, a, b);
      run_op(o, a, b, res, lat, stalls, st_done);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL random[%0d] op%0d %h,%h: got %h want %h", i, o, a, b, res, exp);
      end
      checks++;
      if (lat != el || stalls != el) begin
        errors++;
        $display("FAIL random[%0d] timing: lat %0d stalls %0d want %0d", i, lat, stalls, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o [3] = '{3'd4, 3'd1, 3'd7};
    logic [31:0] a [3] = '{32'hFFFF_FF9C, 32'h8000_0001, 32'hDEAD_BEEF};
    logic [31:0] b [3] = '{32'd9, 32'h0001_0000, 32'h0000_1234};
    logic [31:0] res;
    int lat, stalls;
    logic st_done;
    for (int i = 0; i < 3; i++) begin
      run_op(o[i], a[i], b[i], res, lat, stalls, st_done);
      checks++;
      if (res !== ref_model(o[i], a[i], b[i]) || lat != 33) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h lat %0d want %h lat 33", i, res, lat, ref_model(o[i], a[i], b[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
